// File: rtl/pipe_serializer_pkg.sv
// pipe_serializer shared types and sizing helpers.
// Optional out_last framing is enabled by defining PIPE_SER_LAST_EN.
package pipe_ser_pkg;

  typedef enum logic {
    IDLE,
    SEND
  } ser_state_t;

  function automatic int beats(
    input int in_w,
    input int out_w
  );
    return in_w / out_w;
  endfunction

  function automatic int cnt_w(input int b);
    return (b <= 1) ? 1 : $clog2(b);
  endfunction

endpackage

// File: rtl/pipe_serializer_if.sv
// Wide PipeOut consumer / narrow PipeIn producer bundle.
// out_last exists only when PIPE_SER_LAST_EN is defined.
interface pipe_ser_if #(
  parameter int IN_WIDTH  = 96,
  parameter int OUT_WIDTH = 32
) ();

  logic [IN_WIDTH-1:0]  in_first;
  logic                 in_first__RDY;
  logic                 in_deq__RDY;
  logic                 in_deq__ENA;
  logic [OUT_WIDTH-1:0] out_enq_v;
  logic                 out_enq__ENA;
  logic                 out_enq__RDY;
`ifdef PIPE_SER_LAST_EN
  logic                 out_last;
`endif

  modport master (
    input  in_first,
    input  in_first__RDY,
    input  in_deq__RDY,
    output in_deq__ENA,
    output out_enq_v,
    output out_enq__ENA,
`ifdef PIPE_SER_LAST_EN
    output out_last,
`endif
    input  out_enq__RDY
  );

  modport slave (
    output in_first,
    output in_first__RDY,
    output in_deq__RDY,
    input  in_deq__ENA,
    input  out_enq_v,
    input  out_enq__ENA,
`ifdef PIPE_SER_LAST_EN
    input  out_last,
`endif
    output out_enq__RDY
  );

endinterface

// File: rtl/pipe_serializer.sv
// Wide-to-narrow serializer, LS beat first, no bubble between words.
// Define PIPE_SER_LAST_EN to drive out_last on the final beat.
module pipe_serializer
  import pipe_ser_pkg::*;
#(
  parameter int IN_WIDTH  = 96,
  parameter int OUT_WIDTH = 32
) (
  input  logic       CLK,
  input  logic       nRST,
  pipe_ser_if.master bus
);

  localparam int BEATS = beats(IN_WIDTH, OUT_WIDTH);
  localparam int CW    = cnt_w(BEATS);

  if ((IN_WIDTH % OUT_WIDTH) != 0) begin : g_bad_width
    $fatal(1, "IN_WIDTH must be a multiple of OUT_WIDTH");
  end

  ser_state_t          state;
  ser_state_t          state_n;
  logic [CW-1:0]       cnt;
  logic [IN_WIDTH-1:0] shreg;
  logic                avail;
  logic                last;
  logic                deq;
  logic                enq;

  assign avail = bus.in_deq__RDY & bus.in_first__RDY;
  assign last  = (cnt == CW'(BEATS - 1));

  // nRST gating keeps strobes low while reset is held
  always_comb begin
    state_n = state;
    deq     = 1'b0;
    enq     = 1'b0;
    unique case (state)
      IDLE: begin
        if (avail) begin
          deq     = nRST;
          state_n = SEND;
        end
      end
      SEND: begin
        enq = nRST & bus.out_enq__RDY;
        if (enq && last) begin
          if (avail) deq = 1'b1;
          else state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state <= IDLE;
      cnt   <= '0;
      shreg <= '0;
    end else begin
      state <= state_n;
      if (deq) begin
        shreg <= bus.in_first;
        cnt   <= '0;
      end else if (enq) begin
        shreg <= shreg >> OUT_WIDTH;
        cnt   <= last ? '0 : cnt + CW'(1);
      end
    end
  end

  assign bus.in_deq__ENA  = deq;
  assign bus.out_enq__ENA = enq;
  assign bus.out_enq_v    =
    enq ? shreg[OUT_WIDTH-1:0] : '0;

`ifdef PIPE_SER_LAST_EN
  assign bus.out_last = enq & last;
`endif

endmodule
